// File: rtl/fib_bcd_conv_if.sv
// Handshake bundle between the Fibonacci generator, the BCD converter and the display mux.
interface fib_bcd_conv_if #(
    parameter int N = 4,
    parameter int D = 2
);
    logic           start;
    logic [N-1:0]   bin;
    logic           ready;
    logic           done_tick;
    logic [4*D-1:0] bcd;

    modport master (output start, bin, input ready, done_tick, bcd);
    modport slave  (input start, bin, output ready, done_tick, bcd);
endinterface

// File: rtl/fib_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// state  | meaning
// S_IDLE | waiting for start, ready=1
// S_OP   | adjust+shift one bit per edge, r_cnt counts remaining bits
// S_DONE | bcd holds the new result, done_tick=1 for this cycle
module fib_bcd_conv #(
    parameter int N = 4,
    parameter int D = 2
) (
    input  logic           clk,
    input  logic           reset,
    fib_bcd_conv_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_OP, S_DONE} state_t;

    state_t           r_state;
    logic [N-1:0]     r_bin;
    logic [4*D-1:0]   r_work;
    logic [CW-1:0]    r_cnt;
    logic [4*D-1:0]   r_bcd;
    logic [4*D-1:0]   w_adj;
    logic [4*D-1:0]   w_shift;

    // Each digit is adjusted independently; the +3 wraps mod 16 inside the digit.
    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < D; i++) begin
            if (r_work[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
        end
    end

    assign w_shift = {w_adj[4*D-2:0], r_bin[N-1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bin   <= bus.bin;
                        r_work  <= '0;
                        r_cnt   <= CW'(N);
                        r_state <= S_OP;
                    end
                end
                S_OP: begin
                    r_work <= w_shift;
                    r_bin  <= r_bin << 1;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_bcd   <= w_shift;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready     = (r_state == S_IDLE);
    assign bus.done_tick = (r_state == S_DONE);
    assign bus.bcd       = r_bcd;
endmodule

// File: tb/tb_fib_bcd_conv.sv
// Bench for fib_bcd_conv: an N=4/D=2 and an N=8/D=3 instance against a decimal-digit model.
module tb_fib_bcd_conv;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fib_bcd_conv_if #(.N(4), .D(2)) bus4 ();
    fib_bcd_conv_if #(.N(8), .D(3)) bus8 ();

    fib_bcd_conv #(.N(4), .D(2)) u4 (.clk(clk), .reset(reset), .bus(bus4));
    fib_bcd_conv #(.N(8), .D(3)) u8 (.clk(clk), .reset(reset), .bus(bus8));

    // Reference: decimal digits by repeated division.
    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle4();
        int n = 0;
        while (!bus4.ready && n < 30) begin step(); n++; end
        total++;
        if (bus4.ready !== 1'b1) begin bad++; $display("FAIL idle4_timeout ready=%b want 1", bus4.ready); end
    endtask

    task automatic convert4(input logic [3:0] b);
        logic [11:0] e;
        int n;
        e = to_bcd(int'(b));
        bus4.bin = b; bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        total++;
        if (bus4.ready !== 1'b0) begin bad++; $display("FAIL accept_ready bin=%0d ready=%b want 0", b, bus4.ready); end
        n = 0;
        while (!bus4.done_tick && n < 20) begin
            step(); n++;
            if (!bus4.done_tick) begin
                total++;
                if (bus4.ready !== 1'b0) begin bad++; $display("FAIL busy_ready bin=%0d ready=%b want 0", b, bus4.ready); end
            end
        end
        total++;
        if (n !== 4) begin bad++; $display("FAIL latency bin=%0d got %0d edges want 4", b, n); end
        total++;
        if (bus4.bcd !== e[7:0]) begin bad++; $display("FAIL bcd4 bin=%0d got %h want %h", b, bus4.bcd, e[7:0]); end
        step();
        total++;
        if (bus4.ready !== 1'b1 || bus4.done_tick !== 1'b0 || bus4.bcd !== e[7:0]) begin
            bad++; $display("FAIL after_done bin=%0d ready=%b done=%b bcd=%h want 1 0 %h", b, bus4.ready, bus4.done_tick, bus4.bcd, e[7:0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus4.start = 1'b0; bus4.bin = '0;
        bus8.start = 1'b0; bus8.bin = '0;
        repeat (3) step();
        reset = 1'b1;
        step();
        total++;
        if (bus4.ready !== 1'b1 || bus4.done_tick !== 1'b0 || bus4.bcd !== 8'h00) begin
            bad++; $display("FAIL reset4 ready=%b done=%b bcd=%h want 1 0 00", bus4.ready, bus4.done_tick, bus4.bcd);
        end
        total++;
        if (bus8.ready !== 1'b1 || bus8.done_tick !== 1'b0 || bus8.bcd !== 12'h000) begin
            bad++; $display("FAIL reset8 ready=%b done=%b bcd=%h want 1 0 000", bus8.ready, bus8.done_tick, bus8.bcd);
        end
    endtask

    task automatic test_basic();
        convert4(4'd13);
    endtask

    task automatic test_boundary();
        convert4(4'd0);
        convert4(4'd15);
        convert4(4'd9);
        convert4(4'd10);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) convert4(4'($urandom_range(0, 15)));
    endtask

    task automatic test_ignore_busy();
        int n;
        int pulses;
        bus4.bin = 4'd8; bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        step();
        bus4.bin = 4'd3; bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        n = 0;
        while (!bus4.done_tick && n < 20) begin step(); n++; end
        total++;
        if (bus4.done_tick !== 1'b1 || bus4.bcd !== 8'h08) begin
            bad++; $display("FAIL busy_result done=%b bcd=%h want 1 08", bus4.done_tick, bus4.bcd);
        end
        bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        total++;
        if (bus4.ready !== 1'b1) begin bad++; $display("FAIL done_start_ignored ready=%b want 1", bus4.ready); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin step(); if (bus4.done_tick) pulses++; end
        total++;
        if (pulses !== 0 || bus4.bcd !== 8'h08) begin
            bad++; $display("FAIL busy_extra pulses=%0d bcd=%h want 0 08", pulses, bus4.bcd);
        end
        convert4(4'd3);
    endtask

    task automatic test_reset_mid();
        int pulses;
        bus4.bin = 4'd12; bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        total++;
        if (bus4.ready !== 1'b1 || bus4.done_tick !== 1'b0 || bus4.bcd !== 8'h00) begin
            bad++; $display("FAIL reset_mid ready=%b done=%b bcd=%h want 1 0 00", bus4.ready, bus4.done_tick, bus4.bcd);
        end
        step(); step();
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin step(); if (bus4.done_tick) pulses++; end
        total++;
        if (pulses !== 0 || bus4.bcd !== 8'h00) begin
            bad++; $display("FAIL reset_mid_after pulses=%0d bcd=%h want 0 00", pulses, bus4.bcd);
        end
    endtask

    task automatic test_fib_sweep();
        int fib[14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
        int idx = 0;
        int last = -1;
        int cyc = 0;
        logic [11:0] e;
        bus8.bin = 8'(fib[0]); bus8.start = 1'b1;
        while (idx < 14 && cyc < 200) begin
            step(); cyc++;
            if (bus8.done_tick) begin
                e = to_bcd(fib[idx]);
                total++;
                if (bus8.bcd !== e) begin bad++; $display("FAIL fib_bcd val=%0d got %h want %h", fib[idx], bus8.bcd, e); end
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== 10) begin bad++; $display("FAIL fib_spacing val=%0d got %0d want 10", fib[idx], cyc - last); end
                end
                last = cyc;
                idx++;
                if (idx < 14) bus8.bin = 8'(fib[idx]);
            end
        end
        bus8.start = 1'b0;
        total++;
        if (idx !== 14) begin bad++; $display("FAIL fib_count got %0d want 14", idx); end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int pulses = 0;
        bus4.bin = 4'd7; bus4.start = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (bus4.done_tick) begin
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== 6) begin bad++; $display("FAIL b2b_spacing got %0d want 6", cyc - last); end
                end
                last = cyc;
                pulses++;
            end
            if (pulses > 0) begin
                total++;
                if (bus4.bcd !== 8'h07) begin bad++; $display("FAIL b2b_bcd cyc=%0d got %h want 07", cyc, bus4.bcd); end
            end
        end
        bus4.start = 1'b0;
        total++;
        if (pulses < 6) begin bad++; $display("FAIL b2b_pulses got %0d want >=6", pulses); end
        wait_idle4();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_random();
        test_ignore_busy();
        test_reset_mid();
        test_fib_sweep();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fib_bcd_conv.md
Name: fib_bcd_conv

Overview:
- Sequential binary-to-BCD converter (shift-add-3 / double dabble) sitting directly downstream of the Fibonacci generator.
- Captures the generator's N-bit result on a start pulse.
- Converts the result to D packed BCD digits for the seven-segment display multiplexer.
- One bit is processed per clock; the result is registered and held until the next conversion.

Parameters:
- N, 4, width of the binary input (matches generator result width).
- D, 2, number of BCD output digits; must satisfy 10^D > 2^N - 1. Undersizing D is a configuration error; excess high digits are silently lost.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of bin; sampled only while ready=1.
- bin  input  N  unsigned binary value to convert.
- ready  output  1  high while idle and able to accept start.
- done_tick  output  1  one-cycle pulse; bcd holds the new result during this cycle.
- bcd  output  4*D  packed BCD result. Digit 0 is bits [3:0]; digit i is bits [4i+3:4i].

Behaviour:
- Reset (reset=0, async, any state):
  - state=idle, ready=1, done_tick=0, bcd=0.
  - Internal shift, BCD working and bit-count registers cleared.
  - Takes effect immediately, including mid-conversion; no partial result is ever written to bcd.
- FSM states: idle, op, done. Single state register, default next-state = current.
- idle:
  - ready=1.
  - On a rising edge with start=1: bin_reg<=bin, work<=0, cnt<=N, state<=op.
  - On a rising edge with start=0: remain in idle.
- op:
  - ready=0. start is ignored.
  - Each edge, adjust then shift:
    - Adjust: every 4-bit digit of work that is >=5 has 3 added. Digits are adjusted independently, mod 16 per digit.
    - Shift: {work,bin_reg} is shifted left one bit, with bin_reg MSB entering work bit 0.
    - cnt decrements by 1.
  - On the edge where cnt==1 (the Nth shift): bcd<=shifted work value, state<=done.
- done:
  - done_tick=1 for exactly this one cycle; ready=0.
  - Next edge: state<=idle unconditionally. start during done is ignored.
- Latency:
  - start sampled at edge k -> shifts at edges k+1..k+N -> done_tick high in the cycle following edge k+N.
  - Throughput: one conversion per N+2 cycles.
- start held permanently high: a new conversion begins on the first idle edge. done_tick pulses every N+2 cycles.
- bin is captured only at acceptance. Later changes to bin do not affect the running conversion.
- bcd changes only on the edge entering done, or on reset. It holds its value through idle and op.
- cnt width is clog2(N+1) bits. No wrap is possible since cnt is reloaded only in idle.
- All outputs are driven from registers or decoded from the state register. No combinational path from start/bin to outputs.

Test Plan:
- N=4, D=2. Reset low 3 cycles, then high -> ready=1, done_tick=0, bcd=8'h00. Pulse start with bin=4'd13 -> ready=0 for 5 cycles; done_tick high exactly in the 5th cycle after the start edge (after edge k+4); bcd=8'h13; ready=1 the following cycle.
- N=4, D=2, boundaries: bin=0 -> bcd=8'h00. bin=15 -> bcd=8'h15. bin=9 -> bcd=8'h09 (no adjust carry). bin=10 -> bcd=8'h10.
- Start ignored while busy: start bin=8, then pulse start with bin=3 during op and again during done -> a single done_tick with bcd=8'h08. The bin=3 request is not converted until start is reasserted in idle.
- Reset mid-op: start bin=12, drive reset low 2 edges after acceptance -> immediately ready=1, done_tick=0, bcd=8'h00. No done_tick appears afterwards.
- N=8, D=3, Fibonacci sweep: feed 0,1,1,2,3,5,8,13,21,34,55,89,144,233 with start held high -> each done_tick is 10 cycles apart. bcd matches decimal, e.g. 144 -> 12'h144, 233 -> 12'h233.
- Back-to-back hold: N=4, start stuck high with bin=7 -> done_tick every 6 cycles with bcd=8'h07. bcd is stable between pulses.
